// File: rtl/deserializer_if.sv
// Serial-in / parallel-out handshake bundle for the deserializer.
// slave = the deserializer itself, master = the sample source plus the frame consumer.
interface deserializer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
);
    localparam int LW = $clog2(N_SAMPLES + 1);

    logic [BIT_WIDTH-1:0]           recv_msg;
    logic                           recv_val;
    logic                           recv_rdy;
    logic                           flush;
    logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg;
    logic [LW-1:0]                  send_len;
    logic                           send_val;
    logic                           send_rdy;

    modport slave (
        input  recv_msg, recv_val, flush, send_rdy,
        output recv_rdy, send_msg, send_len, send_val
    );

    modport master (
        output recv_msg, recv_val, flush, send_rdy,
        input  recv_rdy, send_msg, send_len, send_val
    );
endinterface

// File: rtl/deserializer.sv
// Collects N_SAMPLES serial words into one parallel frame, with flush for partial frames.
// Latency: frame valid the cycle after the last word's receive fire (or the flush cycle).
// Backpressure: recv_rdy drops while a frame is pending and send_rdy is low; frame held stable.
module deserializer #(
    parameter  int BIT_WIDTH = 32,
    parameter  int N_SAMPLES = 8,
    localparam int CW        = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    localparam int LW        = $clog2(N_SAMPLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    deserializer_if.slave io
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                               state_q, state_d;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]  data_q, data_d;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [LW-1:0]                        len_q, len_d;

    logic          recv_rdy;
    logic          recv_fire;
    logic          send_fire;
    logic [LW-1:0] k;

    // A pending frame can be replaced in the same cycle it is consumed, so
    // ready follows the consumer combinationally.
    assign recv_rdy  = (state_q == FILL) || io.send_rdy;
    assign recv_fire = io.recv_val && recv_rdy;
    assign send_fire = (state_q == FULL) && io.send_rdy;
    assign k         = LW'(cnt_q) + LW'(recv_fire);

    assign io.recv_rdy = recv_rdy;
    assign io.send_val = (state_q == FULL);
    assign io.send_msg = data_q;
    assign io.send_len = len_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        if (send_fire) begin
            state_d = FILL;
        end

        // In FULL cnt is always 0, so a word arriving alongside a send lands in slot 0.
        if (recv_fire) begin
            data_d[cnt_q] = io.recv_msg;
            if (cnt_q == CW'(N_SAMPLES - 1)) begin
                cnt_d   = '0;
                state_d = FULL;
                len_d   = LW'(N_SAMPLES);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if ((state_q == FILL) && io.flush && (k != '0)) begin
            state_d = FULL;
            len_d   = k;
            cnt_d   = '0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                if (i >= int'(k)) begin
                    data_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            data_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench: N=4/W=8 instance driven from a vector table plus hand sequences, and an N=1 instance.
module tb_deserializer;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    deserializer_if #(.BIT_WIDTH(8), .N_SAMPLES(4)) i4 ();
    deserializer_if #(.BIT_WIDTH(8), .N_SAMPLES(1)) i1 ();

    deserializer #(.BIT_WIDTH(8), .N_SAMPLES(4)) u4 (.clk(clk), .reset(rst), .io(i4.slave));
    deserializer #(.BIT_WIDTH(8), .N_SAMPLES(1)) u1 (.clk(clk), .reset(rst), .io(i1.slave));

    typedef struct {
        logic        rv;
        logic [7:0]  rm;
        logic        fl;
        logic        sr;
        logic        e_rrdy;
        logic        e_sval;
        logic [31:0] e_msg;
        logic [2:0]  e_len;
        logic        cm;
    } vec_t;

    vec_t tbl[$];
    int   vecs = 0;
    int   errs = 0;

    function automatic vec_t mk(logic rv, logic [7:0] rm, logic fl, logic sr,
                                logic er, logic es, logic [31:0] em, logic [2:0] el, logic cm);
        vec_t v;
        v.rv = rv; v.rm = rm; v.fl = fl; v.sr = sr;
        v.e_rrdy = er; v.e_sval = es; v.e_msg = em; v.e_len = el; v.cm = cm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic rv, input logic [7:0] rm, input logic fl, input logic sr);
        i4.recv_val = rv;
        i4.recv_msg = rm;
        i4.flush    = fl;
        i4.send_rdy = sr;
    endtask

    task automatic chk_clean(input string nm);
        chk({nm, " sval"}, 32'(i4.send_val), 32'd0);
        chk({nm, " msg"},  i4.send_msg,      32'd0);
        chk({nm, " len"},  32'(i4.send_len), 32'd0);
        chk({nm, " rrdy"}, 32'(i4.recv_rdy), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        drive4(1'b0, 8'h00, 1'b0, 1'b1);
        i1.recv_val = 1'b0;
        i1.recv_msg = 8'h00;
        i1.flush    = 1'b0;
        i1.send_rdy = 1'b1;

        // basic frame
        tbl.push_back(mk(1, 8'h11, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h44, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h44332211, 4, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0));
        // backpressure: stalled words must not be written
        tbl.push_back(mk(1, 8'ha1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'ha2, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'ha3, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'ha4, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'he1, 0, 0, 0, 1, 32'ha4a3a2a1, 4, 0));
        tbl.push_back(mk(1, 8'he2, 0, 0, 0, 1, 32'ha4a3a2a1, 4, 0));
        tbl.push_back(mk(1, 8'he3, 0, 0, 0, 1, 32'ha4a3a2a1, 4, 0));
        tbl.push_back(mk(1, 8'he4, 0, 0, 0, 1, 32'ha4a3a2a1, 4, 0));
        tbl.push_back(mk(1, 8'he5, 0, 0, 0, 1, 32'ha4a3a2a1, 4, 0));
        tbl.push_back(mk(1, 8'ha5, 0, 1, 1, 1, 32'ha4a3a2a1, 4, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'ha4a3a2a5, 0, 1));
        tbl.push_back(mk(1, 8'hb2, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hb3, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hb4, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'hb4b3b2a5, 4, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0));
        // flush with the word received on the flush cycle
        tbl.push_back(mk(1, 8'haa, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hbb, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hcc, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h00ccbbaa, 3, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 32'h00ccbbaa, 3, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 32'h00ccbbaa, 3, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0));
        // flush alone after one word
        tbl.push_back(mk(1, 8'hdd, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h000000dd, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0));

        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk_clean("reset4");
        chk("reset1 sval", 32'(i1.send_val), 32'd0);
        chk("reset1 msg",  32'(i1.send_msg), 32'd0);
        chk("reset1 rrdy", 32'(i1.recv_rdy), 32'd1);
        cyc();

        for (int i = 0; i < tbl.size(); i++) begin
            drive4(tbl[i].rv, tbl[i].rm, tbl[i].fl, tbl[i].sr);
            #1;
            chk($sformatf("row%0d rrdy", i), 32'(i4.recv_rdy), 32'(tbl[i].e_rrdy));
            chk($sformatf("row%0d sval", i), 32'(i4.send_val), 32'(tbl[i].e_sval));
            if (tbl[i].e_sval || tbl[i].cm)
                chk($sformatf("row%0d msg", i), i4.send_msg, tbl[i].e_msg);
            if (tbl[i].e_sval)
                chk($sformatf("row%0d len", i), 32'(i4.send_len), 32'(tbl[i].e_len));
            cyc();
        end

        // back-to-back: 12 words, frames visible on cycles 4, 8 and 12
        for (int c = 0; c < 13; c++) begin
            logic exp_v;
            int   f;
            drive4(c < 12, 8'(c + 1), 1'b0, 1'b1);
            #1;
            exp_v = (c == 4) || (c == 8) || (c == 12);
            chk($sformatf("b2b%0d rrdy", c), 32'(i4.recv_rdy), 32'd1);
            chk($sformatf("b2b%0d sval", c), 32'(i4.send_val), 32'(exp_v));
            if (exp_v) begin
                f = c / 4 - 1;
                chk($sformatf("b2b%0d msg", c), i4.send_msg,
                    {8'(4*f + 4), 8'(4*f + 3), 8'(4*f + 2), 8'(4*f + 1)});
                chk($sformatf("b2b%0d len", c), 32'(i4.send_len), 32'd4);
            end
            cyc();
        end
        drive4(1'b0, 8'h00, 1'b0, 1'b1);

        // N=1: one-word frame every cycle, no bubble
        for (int c = 0; c < 5; c++) begin
            i1.recv_val = (c < 3);
            i1.recv_msg = 8'(5 + c);
            #1;
            chk($sformatf("n1_%0d rrdy", c), 32'(i1.recv_rdy), 32'd1);
            chk($sformatf("n1_%0d sval", c), 32'(i1.send_val), 32'((c >= 1) && (c <= 3)));
            if ((c >= 1) && (c <= 3)) begin
                chk($sformatf("n1_%0d msg", c), 32'(i1.send_msg), 32'(4 + c));
                chk($sformatf("n1_%0d len", c), 32'(i1.send_len), 32'd1);
            end
            cyc();
        end
        i1.recv_val = 1'b0;

        // reset mid-frame
        drive4(1'b1, 8'h31, 1'b0, 1'b1); cyc();
        drive4(1'b1, 8'h32, 1'b0, 1'b1); cyc();
        drive4(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk_clean("rst_mid");
        cyc();
        for (int c = 0; c < 4; c++) begin
            drive4(1'b1, 8'h41 + 8'(c), 1'b0, 1'b1);
            cyc();
        end
        drive4(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("rst_mid frame sval", 32'(i4.send_val), 32'd1);
        chk("rst_mid frame msg",  i4.send_msg,      32'h44434241);
        // reset while FULL drops the pending frame
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk_clean("rst_full");
        cyc();
        for (int c = 0; c < 4; c++) begin
            drive4(1'b1, 8'h51 + 8'(c), 1'b0, 1'b1);
            cyc();
        end
        drive4(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        chk("rst_full frame sval", 32'(i4.send_val), 32'd1);
        chk("rst_full frame msg",  i4.send_msg,      32'h54535251);
        chk("rst_full frame len",  32'(i4.send_len), 32'd4);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
